// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
// Contents:
//   sched_state_e  - scheduler FSM state encoding
//   BAUD_*         - 3-bit baud codes understood by the transmitter
//   cnt_width()    - width of a counter that can hold a given value
//   cnt_last()     - terminal count for a counter that spans N clocks (N=0 -> 1 clock)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } sched_state_e;

  localparam logic [2:0] BAUD_1200   = 3'b000;
  localparam logic [2:0] BAUD_2400   = 3'b001;
  localparam logic [2:0] BAUD_4800   = 3'b010;
  localparam logic [2:0] BAUD_9600   = 3'b011;
  localparam logic [2:0] BAUD_19200  = 3'b100;
  localparam logic [2:0] BAUD_38400  = 3'b101;
  localparam logic [2:0] BAUD_57600  = 3'b110;
  localparam logic [2:0] BAUD_115200 = 3'b111;

  function automatic int cnt_width(input int max_val);
    if (max_val <= 1) return 1;
    return $clog2(max_val + 1);
  endfunction

  // A state that lasts N clocks counts 0..N-1; N=0 still spends one clock.
  function automatic int cnt_last(input int n);
    return (n > 0) ? n - 1 : 0;
  endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   valid_i[1:0]  - request valids (bit n = requester n)
//   last_grant_i  - index of the requester granted most recently
//   enable_i      - when low no grant is issued
//   grant_o[1:0]  - one-hot grant (all zero when disabled or nobody valid)
module uart_rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  // Requester gi wins if it is valid and either the other side is idle
  // or the other side was the one served last time.
  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign grant_o[gi] = enable_i && valid_i[gi] &&
                         (!valid_i[1-gi] || (last_grant_i != 1'(gi)));
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Schedules 16-bit words from two requesters onto a byte-wide UART
// transmitter, high byte first, with a fixed idle gap between bytes and a
// timeout on the transmitter's busy acknowledge.
// Ports:
//   clk, reset                 - clock (rising edge), async active-low reset
//   reqN_valid/data/ready      - requester handshakes (N = 0,1), accept on valid&&ready
//   Tx_BUSY                    - transmitter busy (synchronous to clk)
//   Tx_WR, Tx_DATA             - one-clock write strobe and the byte to send
//   Tx_EN, baud_select         - transmitter configuration
//   grant_id                   - requester owning the message in flight
//   sched_busy                 - high whenever the scheduler is not idle
//   tx_err                     - sticky ack-timeout flag, cleared on next accept
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter logic [2:0] BAUD_SEL    = BAUD_115200,
  parameter int         GAP_CYCLES  = 16,
  parameter int         ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [15:0] req0_data,
  input  logic [15:0] req1_data,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic        Tx_BUSY,
  output logic        Tx_WR,
  output logic [7:0]  Tx_DATA,
  output logic        Tx_EN,
  output logic [2:0]  baud_select,
  output logic        grant_id,
  output logic        sched_busy,
  output logic        tx_err
);

  localparam int ACK_W = cnt_width(ACK_TIMEOUT);
  localparam int GAP_W = cnt_width(GAP_CYCLES);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(cnt_last(ACK_TIMEOUT));
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(cnt_last(GAP_CYCLES));

  sched_state_e     state_q, state_d;
  logic [7:0]       low_byte_q, low_byte_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             byte_idx_q, byte_idx_d;
  logic             grant_id_q, grant_id_d;
  logic             last_grant_q, last_grant_d;
  logic             tx_err_q, tx_err_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  logic [1:0]  grant;
  logic        arb_en;
  logic        accept;
  logic [15:0] accept_data;
  logic        ack_expired;
  logic        gap_done;

  // Reset is folded into the enable so ready stays low while reset is held,
  // even though the state register already reads IDLE.
  assign arb_en = reset && (state_q == ST_IDLE) && !Tx_BUSY;

  uart_rr_arb2 u_arb (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .enable_i     (arb_en),
    .grant_o      (grant)
  );

  assign accept      = |grant;
  assign accept_data = grant[1] ? req1_data : req0_data;
  assign ack_expired = !Tx_BUSY && (ack_cnt_q == ACK_LAST);
  assign gap_done    = (gap_cnt_q == GAP_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (accept) state_d = ST_SEND;
      ST_SEND:      state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (Tx_BUSY)          state_d = ST_WAIT_DONE;
        else if (ack_expired) state_d = ST_IDLE;
      end
      ST_WAIT_DONE: if (!Tx_BUSY) state_d = ST_GAP;
      ST_GAP:       if (gap_done) state_d = byte_idx_q ? ST_IDLE : ST_SEND;
      default:      state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    Tx_WR      = (state_q == ST_SEND);
    sched_busy = (state_q != ST_IDLE);
  end

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign Tx_DATA     = tx_data_q;
  assign Tx_EN       = reset;
  assign baud_select = BAUD_SEL;
  assign grant_id    = grant_id_q;
  assign tx_err      = tx_err_q;

  // ---------------- Datapath next values ----------------
  // The high byte goes straight into the Tx_DATA register on accept, so only
  // the low byte needs holding; the requester may change its data afterwards.
  always_comb begin
    low_byte_d   = low_byte_q;
    tx_data_d    = tx_data_q;
    byte_idx_d   = byte_idx_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    tx_err_d     = tx_err_q;
    ack_cnt_d    = '0;
    gap_cnt_d    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          low_byte_d   = accept_data[7:0];
          tx_data_d    = accept_data[15:8];
          byte_idx_d   = 1'b0;
          grant_id_d   = grant[1];
          last_grant_d = grant[1];
          tx_err_d     = 1'b0;
        end
      end
      ST_WAIT_ACK: begin
        // Counter stops at its terminal value; the state exits that clock.
        if (ack_expired)   tx_err_d  = 1'b1;
        else if (!Tx_BUSY) ack_cnt_d = ack_cnt_q + 1'b1;
      end
      ST_GAP: begin
        if (!gap_done) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end else if (!byte_idx_q) begin
          byte_idx_d = 1'b1;
          tx_data_d  = low_byte_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      low_byte_q   <= 8'h00;
      tx_data_q    <= 8'h00;
      byte_idx_q   <= 1'b0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      tx_err_q     <= 1'b0;
      ack_cnt_q    <= '0;
      gap_cnt_q    <= '0;
    end else begin
      low_byte_q   <= low_byte_d;
      tx_data_q    <= tx_data_d;
      byte_idx_q   <= byte_idx_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      tx_err_q     <= tx_err_d;
      ack_cnt_q    <= ack_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a default-parameter instance driven
// by a simple transmitter model, plus a GAP_CYCLES=0 instance driven by hand.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_data = 16'h0, req1_data = 16'h0;
  logic        req0_ready, req1_ready;
  logic        Tx_BUSY;
  logic        Tx_WR;
  logic [7:0]  Tx_DATA;
  logic        Tx_EN;
  logic [2:0]  baud_select;
  logic        grant_id, sched_busy, tx_err;

  // GAP_CYCLES=0 instance
  logic        g0_valid = 1'b0;
  logic [15:0] g0_data = 16'h0;
  logic        g0_busy = 1'b0;
  logic        g0_ready0, g0_ready1, g0_wr, g0_en, g0_gid, g0_sbusy, g0_err;
  logic [7:0]  g0_txd;
  logic [2:0]  g0_baud;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.BAUD_SEL(3'b111), .GAP_CYCLES(16), .ACK_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .Tx_BUSY(Tx_BUSY), .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA),
    .Tx_EN(Tx_EN), .baud_select(baud_select),
    .grant_id(grant_id), .sched_busy(sched_busy), .tx_err(tx_err)
  );

  uart_tx_scheduler #(.BAUD_SEL(3'b111), .GAP_CYCLES(0), .ACK_TIMEOUT(64)) dut_g0 (
    .clk(clk), .reset(reset),
    .req0_valid(g0_valid), .req1_valid(1'b0),
    .req0_data(g0_data), .req1_data(16'h0000),
    .req0_ready(g0_ready0), .req1_ready(g0_ready1),
    .Tx_BUSY(g0_busy), .Tx_WR(g0_wr), .Tx_DATA(g0_txd),
    .Tx_EN(g0_en), .baud_select(g0_baud),
    .grant_id(g0_gid), .sched_busy(g0_sbusy), .tx_err(g0_err)
  );

  // Transmitter model: sees Tx_WR at a clock edge, then holds BUSY high for
  // 10 clocks. Every written byte and its grant_id are logged.
  logic       xmit_en = 1'b1;
  logic       busy_force = 1'b0;
  logic       busy_model = 1'b0;
  int         busy_cnt = 0;
  int         wr_count = 0;
  logic [7:0] byte_log[$];
  logic       gid_log[$];

  assign Tx_BUSY = busy_model | busy_force;

  always @(posedge clk) begin
    if (Tx_WR) begin
      wr_count <= wr_count + 1;
      byte_log.push_back(Tx_DATA);
      gid_log.push_back(grant_id);
    end
    if (busy_cnt > 0) begin
      busy_model <= (busy_cnt > 1);
      busy_cnt   <= busy_cnt - 1;
    end else if (Tx_WR && xmit_en) begin
      busy_model <= 1'b1;
      busy_cnt   <= 10;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic cond_met(input int which);
    case (which)
      0:       return Tx_BUSY;
      1:       return !Tx_BUSY;
      2:       return Tx_WR;
      default: return !sched_busy;
    endcase
  endfunction

  // Waits on negedges until the condition holds; cycles = negedges waited.
  task automatic wait_until(input string tag, input int which, input int budget, output int cycles);
    cycles = 0;
    while (!cond_met(which) && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check_eq({tag, "_reached"}, 32'(cond_met(which)), 32'd1);
  endtask

  logic [7:0] exp_bytes [6] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h11, 8'h11};
  logic       exp_gids  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    int viol;

    // ---------- reset values (valid already high during reset) ----------
    repeat (3) @(negedge clk);
    req0_valid = 1'b1;
    req0_data  = 16'h94A1;
    #1;
    check_eq("rst_Tx_WR", Tx_WR, 0);
    check_eq("rst_Tx_DATA", Tx_DATA, 8'h00);
    check_eq("rst_Tx_EN", Tx_EN, 0);
    check_eq("rst_baud", baud_select, 3'b111);
    check_eq("rst_ready0", req0_ready, 0);
    check_eq("rst_ready1", req1_ready, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_sched_busy", sched_busy, 0);
    check_eq("rst_tx_err", tx_err, 0);

    // ---------- single word 0x94A1 ----------
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("run_Tx_EN", Tx_EN, 1);
    check_eq("w0_ready0", req0_ready, 1);
    check_eq("w0_ready1", req1_ready, 0);
    @(negedge clk);
    check_eq("w0_wr_b0", Tx_WR, 1);
    check_eq("w0_data_b0", Tx_DATA, 8'h94);
    check_eq("w0_gid", grant_id, 0);
    check_eq("w0_sbusy", sched_busy, 1);
    check_eq("w0_ready_after", req0_ready, 0);
    req0_valid = 1'b0;
    req0_data  = 16'hFFFF;
    @(negedge clk);
    check_eq("w0_wr_one_clk", Tx_WR, 0);
    wait_until("w0_busy_hi", 0, 20, cyc);
    wait_until("w0_busy_lo", 1, 40, cyc);
    check_eq("w0_data_hold", Tx_DATA, 8'h94);
    wait_until("w0_wr_b1", 2, 100, cyc);
    check_eq("w0_gap_clks", cyc, 17);
    check_eq("w0_data_b1", Tx_DATA, 8'hA1);
    wait_until("w0_done", 3, 100, cyc);
    check_eq("w0_tx_err", tx_err, 0);
    check_eq("w0_wr_pulses", wr_count, 2);
    check_eq("w0_data_hold_end", Tx_DATA, 8'hA1);

    // ---------- round robin, both held valid ----------
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    byte_log.delete();
    gid_log.delete();
    base = wr_count;
    req0_data  = 16'h1111;
    req1_data  = 16'h2222;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    cyc = 0;
    while (wr_count < base + 6 && cyc < 1500) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rr_six_bytes", 32'(wr_count - base), 6);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("rr_byte%0d", i), byte_log[i], exp_bytes[i]);
      check_eq($sformatf("rr_gid%0d", i), gid_log[i], exp_gids[i]);
    end
    wait_until("rr_done", 3, 200, cyc);

    // ---------- ack timeout ----------
    xmit_en    = 1'b0;
    req0_data  = 16'h5A3C;
    req0_valid = 1'b1;
    wait_until("to_wr", 2, 10, cyc);
    check_eq("to_data", Tx_DATA, 8'h5A);
    req0_valid = 1'b0;
    base = wr_count;
    repeat (64) @(negedge clk);
    check_eq("to_err_before", tx_err, 0);
    check_eq("to_sbusy_before", sched_busy, 1);
    @(negedge clk);
    check_eq("to_err_at", tx_err, 1);
    check_eq("to_idle", sched_busy, 0);
    repeat (40) @(negedge clk);
    check_eq("to_no_byte1", 32'(wr_count - base), 1);
    check_eq("to_err_sticky", tx_err, 1);

    // ---------- Tx_BUSY held while req1 valid in IDLE ----------
    xmit_en    = 1'b1;
    busy_force = 1'b1;
    req1_data  = 16'hBEEF;
    req1_valid = 1'b1;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (req0_ready || req1_ready || Tx_WR) viol++;
    end
    check_eq("bz_no_ready_wr", viol, 0);
    check_eq("bz_still_idle", sched_busy, 0);
    busy_force = 1'b0;
    #1;
    check_eq("bz_ready1", req1_ready, 1);
    @(negedge clk);
    check_eq("bz_wr", Tx_WR, 1);
    check_eq("bz_data", Tx_DATA, 8'hBE);
    check_eq("bz_gid", grant_id, 1);
    check_eq("bz_err_cleared", tx_err, 0);
    req1_valid = 1'b0;

    // ---------- reset during WAIT_DONE of byte 0 ----------
    repeat (3) @(negedge clk);
    check_eq("rm_in_flight", sched_busy, 1);
    base  = wr_count;
    reset = 1'b0;
    #1;
    check_eq("rm_Tx_WR", Tx_WR, 0);
    check_eq("rm_Tx_DATA", Tx_DATA, 8'h00);
    check_eq("rm_Tx_EN", Tx_EN, 0);
    check_eq("rm_baud", baud_select, 3'b111);
    check_eq("rm_sbusy", sched_busy, 0);
    check_eq("rm_gid", grant_id, 0);
    check_eq("rm_err", tx_err, 0);
    check_eq("rm_ready", {req1_ready, req0_ready}, 2'b00);
    check_eq("rm_g0_cfg", {g0_en, g0_baud, g0_gid, g0_err, g0_ready1, g0_ready0}, 8'b0111_0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check_eq("rm_no_more_wr", 32'(wr_count - base), 0);
    check_eq("rm_idle", sched_busy, 0);

    // ---------- GAP_CYCLES = 0 ----------
    g0_data  = 16'h3C5A;
    g0_valid = 1'b1;
    @(negedge clk);
    check_eq("g0_wr_b0", g0_wr, 1);
    check_eq("g0_data_b0", g0_txd, 8'h3C);
    g0_valid = 1'b0;
    @(negedge clk);
    check_eq("g0_wr_low", g0_wr, 0);
    g0_busy = 1'b1;
    repeat (3) @(negedge clk);
    g0_busy = 1'b0;
    @(negedge clk);
    check_eq("g0_wr_1clk", g0_wr, 0);
    check_eq("g0_sbusy", g0_sbusy, 1);
    @(negedge clk);
    check_eq("g0_wr_2clk", g0_wr, 1);
    check_eq("g0_data_b1", g0_txd, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter BAUD_SEL, default 3'b111: baud code driven onto baud_select.
REQ-002 SHALL have parameter GAP_CYCLES, default 16: idle clocks between consecutive bytes.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 64: maximum clocks from Tx_WR until Tx_BUSY rises.
REQ-004 SHALL have port clk  in  1  single system clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req0_valid, req1_valid  in  1 each  requester has a 16-bit word pending.
REQ-007 SHALL have ports req0_data, req1_data  in  16 each  word to send, high byte first.
REQ-008 SHALL have ports req0_ready, req1_ready  out  1 each  word accepted when valid&&ready at a clock edge.
REQ-009 SHALL have port Tx_BUSY  in  1  transmitter busy, synchronous to clk.
REQ-010 SHALL have ports Tx_WR  out  1  and Tx_DATA  out  8  transmitter write strobe and byte.
REQ-011 SHALL have ports Tx_EN  out  1  and baud_select  out  3  transmitter configuration.
REQ-012 SHALL have ports grant_id  out  1  (owner of message in flight), sched_busy  out  1, and tx_err  out  1.

Function
REQ-013 SHALL implement states IDLE, SEND, WAIT_ACK, WAIT_DONE, GAP.
REQ-014 In IDLE with Tx_BUSY=0, the scheduler SHALL assert exactly one reqN_ready, chosen round-robin among valid requesters; it SHALL assert no ready otherwise.
REQ-015 Round-robin SHALL grant the requester not granted last when both are valid; last_grant SHALL reset to 1, so req0 wins the first tie.
REQ-016 On accept, the scheduler SHALL capture the data and grant_id, clear tx_err, set byte index 0, and go to SEND.
REQ-017 SEND SHALL assert Tx_WR for exactly one clock with Tx_DATA = data[15:8] (index 0) or data[7:0] (index 1), then go to WAIT_ACK.
REQ-018 Tx_DATA SHALL hold its value from SEND until the next SEND.
REQ-019 WAIT_ACK SHALL go to WAIT_DONE on the first clock with Tx_BUSY=1.
REQ-020 If ACK_TIMEOUT clocks elapse in WAIT_ACK, the scheduler SHALL set tx_err=1, drop the remaining byte, and go to IDLE.
REQ-021 WAIT_DONE SHALL go to GAP on the first clock with Tx_BUSY=0.
REQ-022 GAP SHALL count GAP_CYCLES clocks (a value of 0 means a single-clock pass), then go to SEND with index 1 if index was 0, else to IDLE.
REQ-023 tx_err SHALL be sticky until the next accept.
REQ-024 sched_busy SHALL be 1 in every state except IDLE.
REQ-025 A requester dropping valid after accept SHALL NOT affect the message in flight.
REQ-026 Tx_EN SHALL be 1 and baud_select SHALL equal BAUD_SEL whenever reset is deasserted.
REQ-027 All counters SHALL be sized to hold their parameter, and SHALL NOT wrap within a state.

Reset
REQ-028 While reset=0, the following SHALL hold asynchronously: state=IDLE, Tx_WR=0, Tx_DATA=8'h00, Tx_EN=0, baud_select=BAUD_SEL, both ready=0, grant_id=0, sched_busy=0, tx_err=0, last_grant=1, counters=0.
REQ-029 A reset mid-message SHALL discard the message; the requester SHALL resubmit it.

Structure
REQ-030 State encoding and baud-code constants SHALL live in the shared package uart_pkg.
REQ-031 Round-robin selection SHALL be the sub-module uart_rr_arb2 (inputs: two valids, last_grant, enable; outputs: one-hot grant).

Verification
REQ-032 The bench SHALL cover: req0 0x94A1, transmitter model with BUSY high 10 clocks -> Tx_DATA 0x94 then 0xA1, two Tx_WR pulses, gap >= 16 clocks, tx_err=0.
REQ-033 The bench SHALL cover: req0=0x1111 and req1=0x2222 both held valid -> order 0x11,0x11,0x22,0x22,0x11,0x11..., grant_id alternating.
REQ-034 The bench SHALL cover: Tx_BUSY never rises -> tx_err=1 at 64 clocks after Tx_WR, no second byte, back in IDLE.
REQ-035 The bench SHALL cover: Tx_BUSY=1 while req1 is valid in IDLE -> no ready and no Tx_WR until Tx_BUSY=0.
REQ-036 The bench SHALL cover: reset pulled low in WAIT_DONE of byte 0 -> all outputs at reset values immediately, and no further Tx_WR.
REQ-037 The bench SHALL cover: GAP_CYCLES=0 -> byte 1 Tx_WR exactly 2 clocks after Tx_BUSY falls.
